dram_cmd_arbiter: RTL and testbench

Shares the single ROACH2 DRAM command port between one write client (e.g. a DRAM capture writer) and one read client (e.g. the burst reader). It grants whole bursts with round-robin fairness and passes commands through combinationally during a grant. It forwards cmd_ack backpressure to the granted client and returns read data to the read client. It sits directly between the two clients and the DRAM controller's cmd/rd ports.

---
 rtl/dram_arb_pkg.sv | 17 +
 rtl/dram_rr_pick.sv | 28 ++
 rtl/dram_cmd_arbiter.sv | 122 ++++++++++++
 tb/tb_dram_cmd_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arb_pkg.sv
// Shared types and ROACH2 sizing for the DRAM command-port arbiter.
// The arbiter FSM state and default bus widths live here.
package dram_arb_pkg;

  localparam int unsigned ARB_ADDR_W = 25;
  localparam int unsigned ARB_DATA_W = 288;
  localparam int unsigned ARB_BE_W   = 36;
  localparam int unsigned ARB_LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    WR_BURST,
    RD_BURST,
    GAP
  } arb_state_e;

endpackage

// File: rtl/dram_rr_pick.sv
// Two-way round-robin picker: a lone requester wins, otherwise the
// client that was not served last wins.
module dram_rr_pick (
  input  logic wr_req_i,
  input  logic rd_req_i,
  input  logic last_rd_i,
  output logic pick_wr_o,
  output logic pick_rd_o
);

  always_comb begin
    pick_wr_o = 1'b0;
    pick_rd_o = 1'b0;
    unique case ({wr_req_i, rd_req_i})
      2'b10: pick_wr_o = 1'b1;
      2'b01: pick_rd_o = 1'b1;
      2'b11: begin
        pick_wr_o = last_rd_i;
        pick_rd_o = ~last_rd_i;
      end
      default: begin
        pick_wr_o = 1'b0;
        pick_rd_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dram_cmd_arbiter.sv
// Burst-granular round-robin arbiter sharing one DRAM command port
// between a write client and a read client; read data passes straight through.
module dram_cmd_arbiter
  import dram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ARB_ADDR_W,
  parameter int unsigned DATA_WIDTH = ARB_DATA_W,
  parameter int unsigned BE_WIDTH   = ARB_BE_W,
  parameter int unsigned LEN_WIDTH  = ARB_LEN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [LEN_WIDTH-1:0]  wr_len,
  output logic                  wr_grant,
  input  logic                  wr_cmd_valid,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [BE_WIDTH-1:0]   wr_be,
  output logic                  wr_cmd_ready,
  input  logic                  rd_req,
  input  logic [LEN_WIDTH-1:0]  rd_len,
  output logic                  rd_grant,
  input  logic                  rd_cmd_valid,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_cmd_ready,
  output logic [ADDR_WIDTH-1:0] dram_addr,
  output logic [DATA_WIDTH-1:0] dram_wr_data,
  output logic [BE_WIDTH-1:0]   dram_wr_be,
  output logic                  dram_rwn,
  output logic                  dram_cmd_valid,
  input  logic                  dram_cmd_ack,
  input  logic [DATA_WIDTH-1:0] dram_rd_data,
  input  logic                  dram_rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid
);

  arb_state_e           state_q, state_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic                 last_rd_q, last_rd_d;
  logic                 pick_wr, pick_rd;
  logic                 accept;

  dram_rr_pick u_pick (
    .wr_req_i  (wr_req),
    .rd_req_i  (rd_req),
    .last_rd_i (last_rd_q),
    .pick_wr_o (pick_wr),
    .pick_rd_o (pick_rd)
  );

  // Command mux: idle bus is all zero with rwn parked at read.
  always_comb begin
    wr_grant       = (state_q == WR_BURST);
    rd_grant       = (state_q == RD_BURST);
    dram_cmd_valid = 1'b0;
    dram_rwn       = 1'b1;
    dram_addr      = '0;
    dram_wr_data   = '0;
    dram_wr_be     = '0;
    if (wr_grant) begin
      dram_cmd_valid = wr_cmd_valid;
      dram_rwn       = 1'b0;
      dram_addr      = wr_addr;
      dram_wr_data   = wr_data;
      dram_wr_be     = wr_be;
    end else if (rd_grant) begin
      dram_cmd_valid = rd_cmd_valid;
      dram_addr      = rd_addr;
    end
  end

  assign wr_cmd_ready  = wr_grant & dram_cmd_ack;
  assign rd_cmd_ready  = rd_grant & dram_cmd_ack;
  assign accept        = dram_cmd_valid & dram_cmd_ack;
  assign rd_data       = dram_rd_data;
  assign rd_data_valid = dram_rd_valid;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    last_rd_d = last_rd_q;
    unique case (state_q)
      IDLE: begin
        if (pick_wr) begin
          state_d   = WR_BURST;
          rem_d     = wr_len;
          last_rd_d = 1'b0;
        end else if (pick_rd) begin
          state_d   = RD_BURST;
          rem_d     = rd_len;
          last_rd_d = 1'b1;
        end
      end
      WR_BURST, RD_BURST: begin
        if (accept) begin
          if (rem_q == '0) begin
            state_d = GAP;
          end else begin
            rem_d = rem_q - LEN_WIDTH'(1);
          end
        end
      end
      GAP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      last_rd_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      last_rd_q <= last_rd_d;
    end
  end

endmodule

// File: tb/tb_dram_cmd_arbiter.sv
// Scoreboard bench for dram_cmd_arbiter: random bursts and read returns,
// expected command order derived from the round-robin rules.
module tb_dram_cmd_arbiter;

  typedef struct {
    logic        rd;
    logic [24:0] addr;
    logic [287:0] data;
    logic [35:0] be;
    logic        last;
  } cmd_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_req, rd_req;
  logic [7:0]   wr_len, rd_len;
  logic         wr_grant, rd_grant;
  logic         wr_cmd_valid, rd_cmd_valid;
  logic [24:0]  wr_addr, rd_addr;
  logic [287:0] wr_data;
  logic [35:0]  wr_be;
  logic         wr_cmd_ready, rd_cmd_ready;
  logic [24:0]  dram_addr;
  logic [287:0] dram_wr_data;
  logic [35:0]  dram_wr_be;
  logic         dram_rwn, dram_cmd_valid, dram_cmd_ack;
  logic [287:0] dram_rd_data, rd_data;
  logic         dram_rd_valid, rd_data_valid;

  dram_cmd_arbiter dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_len(wr_len), .wr_grant(wr_grant),
    .wr_cmd_valid(wr_cmd_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .wr_cmd_ready(wr_cmd_ready),
    .rd_req(rd_req), .rd_len(rd_len), .rd_grant(rd_grant),
    .rd_cmd_valid(rd_cmd_valid), .rd_addr(rd_addr),
    .rd_cmd_ready(rd_cmd_ready),
    .dram_addr(dram_addr), .dram_wr_data(dram_wr_data),
    .dram_wr_be(dram_wr_be), .dram_rwn(dram_rwn),
    .dram_cmd_valid(dram_cmd_valid), .dram_cmd_ack(dram_cmd_ack),
    .dram_rd_data(dram_rd_data), .dram_rd_valid(dram_rd_valid),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  cmd_t eq[$];
  cmd_t wq[$];
  cmd_t rq[$];
  logic [287:0] rdq[$];

  bit gw_q = 0, gr_q = 0;
  bit ack_mode = 0;
  bit a5_mode = 0;
  int ack_pct = 100;
  int val_pct = 100;
  bit last_rd_m = 1;
  int exp_glw = 0, exp_glr = 0;
  int glw = 0, glr = 0;
  int since_last = 0;

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s act=%0h want=%0h", nm, act, want);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s (no expected entry)", nm);
  endtask

  function automatic logic [287:0] rnd_data();
    logic [287:0] d;
    for (int i = 0; i < 9; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  function automatic logic [35:0] rnd_be();
    return {4'($urandom()), 32'($urandom())};
  endfunction

  // Drives both clients, the controller ack and the read return path.
  task automatic step();
    bit nw, nr;
    @(posedge clk); #1;
    if (gw_q && wr_cmd_valid && dram_cmd_ack && wq.size() > 0) wq.delete(0);
    if (gr_q && rd_cmd_valid && dram_cmd_ack && rq.size() > 0) rq.delete(0);
    nw = wr_grant;
    nr = rd_grant;
    if (nw) wr_req = 1'b0;
    if (nr) rd_req = 1'b0;
    if (ack_mode)
      dram_cmd_ack = ((nw && !gw_q) || (nr && !gr_q)) ? 1'b0 : !dram_cmd_ack;
    else
      dram_cmd_ack = ($urandom_range(0, 99) < ack_pct);
    if (nw && wq.size() > 0) begin
      wr_cmd_valid = ($urandom_range(0, 99) < val_pct);
      wr_addr = wq[0].addr;
      wr_data = wq[0].data;
      wr_be   = wq[0].be;
    end else begin
      wr_cmd_valid = 1'($urandom_range(0, 1));
      wr_addr = 25'($urandom());
      wr_data = rnd_data();
      wr_be   = rnd_be();
    end
    if (nr && rq.size() > 0) begin
      rd_cmd_valid = ($urandom_range(0, 99) < val_pct);
      rd_addr = rq[0].addr;
    end else begin
      rd_cmd_valid = 1'($urandom_range(0, 1));
      rd_addr = 25'($urandom());
    end
    dram_rd_valid = ($urandom_range(0, 99) < 30);
    dram_rd_data  = a5_mode ? {36{8'hA5}} : rnd_data();
    if (dram_rd_valid) rdq.push_back(dram_rd_data);
    gw_q = nw;
    gr_q = nr;
  endtask

  always @(negedge clk) begin : mon
    logic [1:0]   g;
    logic [352:0] act;
    cmd_t         e;
    g = {wr_grant, rd_grant};
    act = {dram_cmd_valid, dram_rwn, dram_addr, dram_wr_data,
           dram_wr_be, wr_cmd_ready, rd_cmd_ready};
    case (g)
      2'b00: chk("idle_outputs", 512'(act),
                 512'({1'b0, 1'b1, 25'd0, 288'd0, 36'd0, 2'b00}));
      2'b10: chk("wr_mux", 512'(act),
                 512'({wr_cmd_valid, 1'b0, wr_addr, wr_data, wr_be,
                       dram_cmd_ack, 1'b0}));
      2'b01: chk("rd_mux", 512'(act),
                 512'({rd_cmd_valid, 1'b1, rd_addr, 288'd0, 36'd0,
                       1'b0, dram_cmd_ack}));
      default: chk("grant_onehot", 512'(g), 512'(2'b10));
    endcase
    chk("rd_valid_pass", 512'(rd_data_valid), 512'(dram_rd_valid));
    if (rd_data_valid === 1'b1) begin
      if (rdq.size() == 0) fail_now("rd_return_extra");
      else chk("rd_data", 512'(rd_data), 512'(rdq.pop_front()));
    end
    if (since_last == 1 || since_last == 2)
      chk("gap_no_grant", 512'(g), 512'(2'b00));
    if (since_last == 3 && eq.size() > 0)
      chk("next_grant", 512'(g), 512'(eq[0].rd ? 2'b01 : 2'b10));
    if (since_last > 0 && since_last < 3) since_last++;
    else since_last = 0;
    if (g != 2'b00 && dram_cmd_valid && dram_cmd_ack) begin
      if (eq.size() == 0) fail_now("unexpected_cmd");
      else begin
        e = eq.pop_front();
        chk("cmd", 512'({dram_rwn, dram_addr, dram_wr_data, dram_wr_be}),
            512'({e.rd, e.addr, e.data, e.be}));
        if (e.last) since_last = 1;
      end
    end
    if (wr_grant) glw++;
    else begin
      if (glw > 0 && exp_glw > 0)
        chk("wr_grant_len", 512'(glw), 512'(exp_glw));
      glw = 0;
    end
    if (rd_grant) glr++;
    else begin
      if (glr > 0 && exp_glr > 0)
        chk("rd_grant_len", 512'(glr), 512'(exp_glr));
      glr = 0;
    end
  end

  task automatic run_scn(input bit dw, input int wl, input bit dr,
                         input int rl, input int egw, input int egr);
    bit   win_rd;
    cmd_t c;
    int   guard;
    exp_glw = egw;
    exp_glr = egr;
    win_rd = (dw && dr) ? !last_rd_m : dr;
    if (dw) for (int i = 0; i <= wl; i++) begin
      c.rd = 1'b0;
      c.addr = 25'($urandom());
      c.data = rnd_data();
      c.be = rnd_be();
      c.last = (i == wl);
      wq.push_back(c);
    end
    if (dr) for (int i = 0; i <= rl; i++) begin
      c.rd = 1'b1;
      c.addr = 25'($urandom());
      c.data = '0;
      c.be = '0;
      c.last = (i == rl);
      rq.push_back(c);
    end
    if (win_rd) begin
      foreach (rq[i]) eq.push_back(rq[i]);
      foreach (wq[i]) eq.push_back(wq[i]);
    end else begin
      foreach (wq[i]) eq.push_back(wq[i]);
      foreach (rq[i]) eq.push_back(rq[i]);
    end
    last_rd_m = (dw && dr) ? !win_rd : dr;
    wr_len = 8'(wl);
    rd_len = 8'(rl);
    wr_req = dw;
    rd_req = dr;
    step();
    chk("req_to_grant", 512'({wr_grant, rd_grant}),
        512'(win_rd ? 2'b01 : 2'b10));
    guard = 0;
    while ((wq.size() > 0 || rq.size() > 0) && guard < 3000) begin
      step();
      guard++;
    end
    chk("burst_done", 512'(wq.size() + rq.size()), 512'(0));
    if (wq.size() + rq.size() > 0) begin
      wq.delete();
      rq.delete();
      eq.delete();
      wr_req = 1'b0;
      rd_req = 1'b0;
    end
    repeat (3 + $urandom_range(0, 2)) step();
    chk("idle_after", 512'({wr_grant, rd_grant}), 512'(2'b00));
  endtask

  initial begin
    cmd_t c;
    rst = 1'b0;
    wr_req = 0; rd_req = 0; wr_len = 0; rd_len = 0;
    wr_cmd_valid = 0; rd_cmd_valid = 0;
    wr_addr = 0; rd_addr = 0; wr_data = 0; wr_be = 0;
    dram_cmd_ack = 0; dram_rd_data = 0; dram_rd_valid = 0;
    repeat (3) step();
    chk("reset_state",
        512'({wr_grant, rd_grant, wr_cmd_ready, rd_cmd_ready,
              dram_cmd_valid, dram_rwn, dram_addr, dram_wr_data,
              dram_wr_be}),
        512'({5'b00000, 1'b1, 25'd0, 288'd0, 36'd0}));
    rst = 1'b1;
    step();

    run_scn(1, 1, 1, 1, 2, 2);
    a5_mode = 1;
    run_scn(1, 3, 0, 0, 4, 0);
    a5_mode = 0;
    ack_mode = 1;
    run_scn(0, 0, 1, 7, 0, 16);
    ack_mode = 0;
    run_scn(1, 255, 0, 0, 256, 0);
    run_scn(1, 2, 1, 0, 3, 1);

    for (int s = 0; s < 40; s++) begin
      int kind;
      ack_pct = $urandom_range(40, 100);
      val_pct = $urandom_range(50, 100);
      kind = $urandom_range(1, 3);
      run_scn(kind[0], $urandom_range(0, 15), kind[1],
              $urandom_range(0, 15), 0, 0);
    end

    ack_pct = 100;
    val_pct = 100;
    exp_glw = 0;
    exp_glr = 0;
    for (int i = 0; i <= 4; i++) begin
      c.rd = 1'b1;
      c.addr = 25'($urandom());
      c.data = '0;
      c.be = '0;
      c.last = (i == 4);
      rq.push_back(c);
      eq.push_back(c);
    end
    rd_len = 8'd4;
    rd_req = 1'b1;
    step();
    chk("rst_req_to_grant", 512'({wr_grant, rd_grant}), 512'(2'b01));
    step();
    step();
    chk("rst_two_accepted", 512'(rq.size()), 512'(3));
    rst = 1'b0;
    wr_req = 1'b1;
    step();
    chk("rst_mid_burst",
        512'({wr_grant, rd_grant, dram_cmd_valid, dram_rwn, rd_cmd_ready}),
        512'(5'b00010));
    rq.delete();
    eq.delete();
    step();
    rst = 1'b1;
    last_rd_m = 1'b1;
    run_scn(1, 1, 1, 1, 2, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
